// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the data-cache controller.
//   BLOCK_SIZE / WORD_SIZE  block and word widths
//   `BLOCK0..`BLOCK3        bit slices of the four words inside a block
//   cstate_e                controller FSM states
//   wr_op_e                 line-array write port operations
//   get_word / set_word     word select / word merge helpers
// Optional feature macro (used by dcache_mem_ctrl): DCACHE_STATS_EN.

`define BLOCK0 15:0
`define BLOCK1 31:16
`define BLOCK2 47:32
`define BLOCK3 63:48

package cache_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int WORD_SIZE  = 16;
  localparam int ADDR_W     = 16;
  localparam int OFF_W      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    WB_HOLD = 3'd2,
    REFILL  = 3'd3,
    FILL    = 3'd4
  } cstate_e;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_WORD  = 2'd1,
    WR_FILL  = 2'd2,
    WR_CLEAN = 2'd3
  } wr_op_e;

  function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                    input logic [OFF_W-1:0] off);
    logic [WORD_SIZE-1:0] w;
    case (off)
      2'd0:    w = blk[`BLOCK0];
      2'd1:    w = blk[`BLOCK1];
      2'd2:    w = blk[`BLOCK2];
      default: w = blk[`BLOCK3];
    endcase
    return w;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] set_word(input logic [BLOCK_SIZE-1:0] blk,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic [WORD_SIZE-1:0] w);
    logic [BLOCK_SIZE-1:0] b;
    b = blk;
    case (off)
      2'd0:    b[`BLOCK0] = w;
      2'd1:    b[`BLOCK1] = w;
      2'd2:    b[`BLOCK2] = w;
      default: b[`BLOCK3] = w;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage for a direct-mapped cache.
//   rd_index, rd_tag   -> rd_hit, rd_valid, rd_dirty, rd_line_tag, rd_data (combinational)
//   wr_op              WR_WORD  : write one word, set dirty
//                      WR_FILL  : write whole block + tag, set valid, dirty=wr_dirty
//                      WR_CLEAN : clear dirty
//   reset_n low (sync) invalidates every line and suppresses any write that cycle.

module dcache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IDX_W-1:0]      rd_index,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_hit,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_line_tag,
  output logic [BLOCK_SIZE-1:0] rd_data,
  input  wr_op_e                wr_op,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [OFF_W-1:0]      wr_offset,
  input  logic [WORD_SIZE-1:0]  wr_word,
  input  logic [BLOCK_SIZE-1:0] wr_block,
  input  logic                  wr_dirty
);

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [TAG_W-1:0]      tag_d  [NUM_LINES];
  logic [BLOCK_SIZE-1:0] data_q [NUM_LINES];
  logic [BLOCK_SIZE-1:0] data_d [NUM_LINES];

  always_comb begin
    rd_valid    = valid_q[rd_index];
    rd_dirty    = dirty_q[rd_index];
    rd_line_tag = tag_q[rd_index];
    rd_data     = data_q[rd_index];
    rd_hit      = rd_valid && (rd_line_tag == rd_tag);
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (wr_op)
      WR_WORD: begin
        data_d[wr_index]  = set_word(data_q[wr_index], wr_offset, wr_word);
        dirty_d[wr_index] = 1'b1;
      end
      WR_FILL: begin
        data_d[wr_index]  = wr_block;
        tag_d[wr_index]   = wr_tag;
        valid_d[wr_index] = 1'b1;
        dirty_d[wr_index] = wr_dirty;
      end
      WR_CLEAN: dirty_d[wr_index] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag/data need no reset; gating on reset_n keeps an aborted fill from landing.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   CPU side : cpu_read/cpu_write/cpu_address/cpu_wdata in, cpu_rdata/cpu_ready out
//   Mem side : mem_read/mem_write/mem_address out, mem_data 64-bit inout block bus
//   Optional : `define DCACHE_STATS_EN adds hit_count/miss_count outputs.
//
// state   | meaning
// IDLE    | serve hits combinationally, detect misses
// WB      | drive dirty victim block on mem_data, mem_write=1
// WB_HOLD | bus released, address held while memory commits; clear dirty
// REFILL  | mem_read=1 for MEM_LATENCY cycles
// FILL    | capture block (merged with store data) into the line

module dcache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  inout  wire  [BLOCK_SIZE-1:0] mem_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  cstate_e               state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic                  req_store_q, req_store_d;
  logic [WORD_SIZE-1:0]  req_wdata_q, req_wdata_d;
  logic [ADDR_W-1:0]     maddr_q, maddr_d;

  logic [ADDR_W-1:0]     lk_addr;
  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [OFF_W-1:0]      lk_off;
  logic                  req_valid;

  logic                  rd_hit, rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_line_tag;
  logic [BLOCK_SIZE-1:0] rd_data;
  wr_op_e                wr_op;
  logic [BLOCK_SIZE-1:0] wr_block;
  logic                  wr_dirty;

  // IDLE looks up the live CPU address; every other state works on the latched miss.
  assign lk_addr   = (state_q == IDLE) ? cpu_address : req_addr_q;
  assign lk_off    = lk_addr[OFF_W-1:0];
  assign lk_idx    = lk_addr[OFF_W +: IDX_W];
  assign lk_tag    = lk_addr[ADDR_W-1 -: TAG_W];
  assign req_valid = reset_n && (cpu_read || cpu_write);

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_index    (lk_idx),
    .rd_tag      (lk_tag),
    .rd_hit      (rd_hit),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_line_tag (rd_line_tag),
    .rd_data     (rd_data),
    .wr_op       (wr_op),
    .wr_index    (lk_idx),
    .wr_tag      (lk_tag),
    .wr_offset   (lk_off),
    .wr_word     (cpu_wdata),
    .wr_block    (wr_block),
    .wr_dirty    (wr_dirty)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    req_addr_d  = req_addr_q;
    req_store_d = req_store_q;
    req_wdata_d = req_wdata_q;
    maddr_d     = maddr_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    wr_op       = WR_NONE;
    wr_block    = mem_data;
    wr_dirty    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (rd_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = get_word(rd_data, lk_off);
            if (cpu_write) wr_op = WR_WORD;
          end else begin
            req_addr_d  = cpu_address;
            req_store_d = cpu_write;
            req_wdata_d = cpu_wdata;
            if (rd_valid && rd_dirty) begin
              maddr_d = {rd_line_tag, lk_idx, 2'b00};
              state_d = WB;
            end else begin
              maddr_d = {lk_tag, lk_idx, 2'b00};
              lat_d   = LAT_LOAD;
              state_d = REFILL;
            end
          end
        end
      end
      WB: state_d = WB_HOLD;
      WB_HOLD: begin
        wr_op   = WR_CLEAN;
        maddr_d = {lk_tag, lk_idx, 2'b00};
        lat_d   = LAT_LOAD;
        state_d = REFILL;
      end
      REFILL: begin
        if (lat_q == '0) state_d = FILL;
        else             lat_d   = lat_q - 1'b1;
      end
      FILL: begin
        wr_op = WR_FILL;
        if (req_store_q) begin
          wr_block = set_word(mem_data, lk_off, req_wdata_q);
          wr_dirty = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      req_addr_q  <= '0;
      req_store_q <= 1'b0;
      req_wdata_q <= '0;
      maddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      req_addr_q  <= req_addr_d;
      req_store_q <= req_store_d;
      req_wdata_q <= req_wdata_d;
      maddr_q     <= maddr_d;
    end
  end

  assign mem_read    = (state_q == REFILL);
  assign mem_write   = (state_q == WB);
  assign mem_address = maddr_q;
  assign mem_data    = (state_q == WB) ? rd_data : {BLOCK_SIZE{1'bz}};

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q, hit_d, miss_q, miss_d;
  logic        miss_pend_q, miss_pend_d;

  // A ready that follows its own refill is the tail of a miss, not a hit.
  always_comb begin
    hit_d       = hit_q;
    miss_d      = miss_q;
    miss_pend_d = miss_pend_q;
    if (state_d == REFILL && state_q != REFILL) begin
      miss_pend_d = 1'b1;
      if (miss_q != 16'hffff) miss_d = miss_q + 16'd1;
    end
    if (cpu_ready) begin
      miss_pend_d = 1'b0;
      if (!miss_pend_q && hit_q != 16'hffff) hit_d = hit_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_q       <= '0;
      miss_q      <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: directed scenarios plus randomized load/store traffic for
// dcache_mem_ctrl, checked against a word-level shadow memory and a per-index
// {valid,dirty,tag} latency model. Second instance runs MEM_LATENCY=3.

module tb_dcache_mem_ctrl;

  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_address = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, mem_read, mem_write;
  logic [15:0] mem_address;
  wire  [63:0] mem_data;

  logic        cpu_read_3 = 1'b0, cpu_write_3 = 1'b0;
  logic [15:0] cpu_address_3 = '0, cpu_wdata_3 = '0;
  logic [15:0] cpu_rdata_3;
  logic        cpu_ready_3, mem_read_3, mem_write_3;
  logic [15:0] mem_address_3;
  wire  [63:0] mem_data_3;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];
  bit          m_valid [4];
  bit          m_dirty [4];
  int          m_tag   [4];

  logic        drv, drv_3;
  logic [63:0] blk, blk_3;
  int          rd_cnt = 0, rd_cnt_3 = 0, wr_cnt = 0;
  logic [15:0] rd_addr_last, wb_addr;
  logic [63:0] wb_data;
  logic        prev_mw = 1'b0;
  logic [15:0] prev_ma = '0;

  always #5 clk = ~clk;

  dcache_mem_ctrl #(.NUM_LINES(4), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data(mem_data)
  );

  dcache_mem_ctrl #(.NUM_LINES(4), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read_3), .cpu_write(cpu_write_3), .cpu_address(cpu_address_3),
    .cpu_wdata(cpu_wdata_3), .cpu_rdata(cpu_rdata_3), .cpu_ready(cpu_ready_3),
    .mem_read(mem_read_3), .mem_write(mem_write_3), .mem_address(mem_address_3),
    .mem_data(mem_data_3)
  );

  // Block memory: registered read, drives the block the cycle after mem_read.
  always @(posedge clk) begin
    if (!reset_n) begin
      drv   <= 1'b0;
      drv_3 <= 1'b0;
    end else begin
      drv   <= mem_read;
      drv_3 <= mem_read_3;
    end
    if (mem_write)
      for (int i = 0; i < 4; i++) mem[8'(mem_address[7:0] + i)] <= mem_data[16*i +: 16];
    if (mem_read)
      blk <= {mem[8'(mem_address[7:0] + 3)], mem[8'(mem_address[7:0] + 2)],
              mem[8'(mem_address[7:0] + 1)], mem[mem_address[7:0]]};
    if (mem_read_3)
      blk_3 <= {mem[8'(mem_address_3[7:0] + 3)], mem[8'(mem_address_3[7:0] + 2)],
                mem[8'(mem_address_3[7:0] + 1)], mem[mem_address_3[7:0]]};
  end

  assign mem_data   = drv   ? blk   : {64{1'bz}};
  assign mem_data_3 = drv_3 ? blk_3 : {64{1'bz}};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Bus monitor.
  always @(negedge clk) begin
    if (mem_read)   begin rd_cnt++; rd_addr_last = mem_address; end
    if (mem_read_3) rd_cnt_3++;
    if (mem_read || mem_write) chk("rd_wr_exclusive", {62'd0, mem_read, mem_write} & 64'h0, {62'd0, mem_read & mem_write, 1'b0});
    if (mem_write) begin
      wr_cnt++;
      wb_addr = mem_address;
      wb_data = mem_data;
      chk("wb_block_vs_shadow", mem_data,
          {shadow[8'(mem_address[7:0] + 3)], shadow[8'(mem_address[7:0] + 2)],
           shadow[8'(mem_address[7:0] + 1)], shadow[mem_address[7:0]]});
    end
    if (prev_mw && !mem_write) chk("wb_addr_hold", {48'd0, mem_address}, {48'd0, prev_ma});
    prev_mw = mem_write;
    prev_ma = mem_address;
  end

  task automatic do_req(input bit st, input logic [15:0] a, input logic [15:0] d, input string name);
    int idx, tg, exp_lat, cyc;
    logic [15:0] exp_rd;
    idx = int'(a[3:2]);
    tg  = int'(a[15:4]);
    exp_rd = shadow[a[7:0]];
    if (m_valid[idx] && m_tag[idx] == tg) exp_lat = 0;
    else if (m_valid[idx] && m_dirty[idx]) exp_lat = ML + 4;
    else exp_lat = ML + 2;
    @(posedge clk); #1;
    cpu_address = a; cpu_wdata = d; cpu_read = !st; cpu_write = st;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (cpu_ready) break;
      cyc++;
      if (cyc > 40) break;
      @(posedge clk);
    end
    chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    if (!st) chk({name, "_rdata"}, {48'd0, cpu_rdata}, {48'd0, exp_rd});
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (exp_lat != 0) m_dirty[idx] = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (st) begin
      m_dirty[idx] = 1'b1;
      shadow[a[7:0]] = d;
    end
  endtask

  initial begin
    int cyc, rc;
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] <= v;
      shadow[i] = v;
    end
    mem[0] <= 16'h9023; shadow[0] = 16'h9023;
    mem[1] <= 16'h0001; shadow[1] = 16'h0001;
    mem[2] <= 16'hffff; shadow[2] = 16'hffff;
    mem[3] <= 16'h5a5a; shadow[3] = 16'h5a5a;
    mem[8'h25] <= 16'hf41c; shadow[8'h25] = 16'hf41c;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read",  {63'd0, mem_read},  64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_mem_addr",  {48'd0, mem_address}, 64'd0);
    chk("rst_cpu_rdata", {48'd0, cpu_rdata}, 64'd0);
    chk("rst_cpu_ready", {63'd0, cpu_ready}, 64'd0);
    reset_n = 1'b1;

    // MEM_LATENCY=3 cold load.
    @(posedge clk); #1;
    cpu_address_3 = 16'h0002; cpu_read_3 = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (cpu_ready_3) break;
      cyc++;
      if (cyc > 40) break;
      @(posedge clk);
    end
    chk("lat3_latency", 64'(cyc), 64'd5);
    chk("lat3_rdata", {48'd0, cpu_rdata_3}, 64'h0000_0000_0000_ffff);
    chk("lat3_mem_read_cycles", 64'(rd_cnt_3), 64'd3);
    @(posedge clk); #1;
    cpu_read_3 = 1'b0;

    // Cold load, then hit in the same block.
    rc = rd_cnt;
    do_req(0, 16'h0002, 16'h0, "cold_load");
    chk("cold_mem_read_cycles", 64'(rd_cnt - rc), 64'd1);
    chk("cold_mem_addr", {48'd0, rd_addr_last}, 64'd0);
    chk("cold_rdata_const", {48'd0, cpu_rdata}, 64'h0000_0000_0000_ffff);
    rc = rd_cnt;
    do_req(0, 16'h0001, 16'h0, "hit_load");
    chk("hit_no_mem_read", 64'(rd_cnt - rc), 64'd0);

    // Store hit, then conflict miss forces a write-back.
    do_req(1, 16'h0003, 16'habcd, "store_hit");
    rc = wr_cnt;
    do_req(0, 16'h0010, 16'h0, "wb_load");
    chk("wb_cycles", 64'(wr_cnt - rc), 64'd1);
    chk("wb_addr", {48'd0, wb_addr}, 64'd0);
    chk("wb_data", wb_data, 64'habcd_ffff_0001_9023);
    chk("wb_mem3", {48'd0, mem[3]}, 64'h0000_0000_0000_abcd);

    // Store miss allocates and merges.
    do_req(1, 16'h0024, 16'h1234, "store_miss");
    do_req(0, 16'h0024, 16'h0, "merged_w0");
    chk("merged_w0_const", {48'd0, cpu_rdata}, 64'h0000_0000_0000_1234);
    do_req(0, 16'h0025, 16'h0, "merged_w1");
    chk("merged_w1_const", {48'd0, cpu_rdata}, 64'h0000_0000_0000_f41c);
    do_req(0, 16'h0004, 16'h0, "dirty_evict");
    chk("dirty_evict_addr", {48'd0, wb_addr}, 64'h0000_0000_0000_0024);
    chk("dirty_evict_w0", {48'd0, mem[8'h24]}, 64'h0000_0000_0000_1234);

    // Reset in the middle of a refill.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    @(posedge clk); #1;
    cpu_address = 16'h0002; cpu_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_mem_read", {63'd0, mem_read}, 64'd1);
    reset_n = 1'b0; cpu_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_read", {63'd0, mem_read}, 64'd0);
    chk("abort_cpu_ready", {63'd0, cpu_ready}, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    do_req(0, 16'h0002, 16'h0, "post_abort_load");

    // Random traffic over 16 blocks sharing 4 lines.
    for (int n = 0; n < 200; n++)
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom), "rand");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
